// File: rtl/auth_sequence_checker.sv
// Per-user code checker with a timed one-hot grant, a global failure counter
// and a timed lockout. A granted user may overwrite their own stored code.
module auth_sequence_checker #(
  parameter int CODE_W       = 3,
  parameter int N_USERS      = 3,
  parameter int MAX_TRIES    = 3,
  parameter int GRANT_CYCLES = 4,
  parameter int LOCK_CYCLES  = 8,
  localparam int UW = (N_USERS > 1) ? $clog2(N_USERS) : 1,
  localparam int TW = $clog2(MAX_TRIES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] code_in,
  input  logic [UW-1:0]     user_sel,
  input  logic              submit,
  input  logic              prog,
  output logic [N_USERS-1:0] AUT,
  output logic              deny,
  output logic              locked,
  output logic [TW-1:0]     tries_left,
  output logic              busy
);

  localparam int DUR_MAX = (GRANT_CYCLES > LOCK_CYCLES) ? GRANT_CYCLES : LOCK_CYCLES;
  localparam int CW      = $clog2(DUR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DENY,
    S_GRANT,
    S_LOCKED
  } state_t;

  state_t              state;
  logic [CODE_W-1:0]   code_mem [N_USERS];
  logic [CODE_W-1:0]   cap_code;
  logic [UW-1:0]       cap_user;
  logic [CW-1:0]       dur;
  logic                code_match;
  logic [N_USERS-1:0]  grant_vec;
  logic                prog_hit;
  logic [TW-1:0]       tries_dec;

  // An out-of-range cap_user never matches any loop index, so it yields a mismatch.
  always_comb begin
    code_match = 1'b0;
    grant_vec  = '0;
    for (int unsigned i = 0; i < N_USERS; i++) begin
      if (cap_user == UW'(i)) begin
        code_match   = (cap_code == code_mem[i]);
        grant_vec[i] = 1'b1;
      end
    end
  end

  assign prog_hit  = submit && prog && (user_sel == cap_user);
  assign tries_dec = tries_left - TW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      AUT        <= '0;
      deny       <= 1'b0;
      locked     <= 1'b0;
      busy       <= 1'b0;
      tries_left <= TW'(MAX_TRIES);
      cap_code   <= '0;
      cap_user   <= '0;
      dur        <= '0;
      for (int unsigned i = 0; i < N_USERS; i++) code_mem[i] <= '0;
    end else begin
      deny <= 1'b0;
      case (state)
        S_IDLE: begin
          if (submit) begin
            cap_code <= code_in;
            cap_user <= user_sel;
            state    <= S_CHECK;
            busy     <= 1'b1;
          end
        end
        S_CHECK: begin
          if (code_match) begin
            state      <= S_GRANT;
            AUT        <= grant_vec;
            tries_left <= TW'(MAX_TRIES);
            dur        <= CW'(GRANT_CYCLES - 1);
          end else begin
            deny       <= 1'b1;
            tries_left <= tries_dec;
            if (tries_dec == '0) begin
              state  <= S_LOCKED;
              locked <= 1'b1;
              dur    <= CW'(LOCK_CYCLES - 1);
            end else begin
              state <= S_DENY;
            end
          end
        end
        S_DENY: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        S_GRANT: begin
          // AUT is one-hot on cap_user here, so it doubles as the write select.
          if (prog_hit || dur == '0) begin
            if (prog_hit) begin
              for (int unsigned i = 0; i < N_USERS; i++)
                if (AUT[i]) code_mem[i] <= code_in;
            end
            AUT   <= '0;
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            dur <= dur - CW'(1);
          end
        end
        S_LOCKED: begin
          if (dur == '0) begin
            locked     <= 1'b0;
            tries_left <= TW'(MAX_TRIES);
            state      <= S_IDLE;
            busy       <= 1'b0;
          end else begin
            dur <= dur - CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
